prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader upstream of the 8-bit CPU core.
- Accepts a length-prefixed byte stream over a valid/ready handshake, e.g. from a UART receiver.
- Writes the bytes into main memory starting at address 0, holding the CPU in reset throughout.
- Then releases the CPU's reset so the PC starts fetching at 0x00 with the new program in place.

Parameters:
- ADDR_W, 8, memory address width; maximum program length is 2^ADDR_W bytes.
- DATA_W, 8, byte/instruction width.
- RST_HOLD, 4, number of cycles cpu_reset stays high after the last memory write (range 1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  incoming stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte this cycle.
- load_req  in  1  request a reload; sampled only in RUN and ERROR.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  one-cycle memory write strobe.
- cpu_reset  out  1  active-high reset to the PC/CPU.
- busy  out  1  loader is in LEN, DATA, CSUM or HOLD.
- done  out  1  program loaded and CPU released.
- err  out  1  checksum failure; only driven when the optional feature is enabled, otherwise tied 0.

Behaviour:
- States: LEN, DATA, CSUM (optional), HOLD, RUN, ERROR.
- Reset (reset==0 at a clock edge):
  - state=LEN; cpu_reset=1; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; done=0; err=0; busy=1.
  - Byte count, hold counter and checksum are cleared.
- Handshake:
  - A byte transfers when in_valid && in_ready at a rising edge.
  - in_ready is 1 only in LEN, DATA and CSUM; it is registered.
  - The producer must hold in_data stable while in_valid && !in_ready.
- LEN:
  - The accepted byte N sets remaining = N, with N==0 meaning 2^ADDR_W bytes (256).
  - The write address counter is set to 0. Next state is DATA.
- DATA:
  - Each accepted byte at edge t produces, at t+1, mem_we=1 for exactly one cycle, mem_addr=current counter, mem_wdata=byte.
  - The counter increments modulo 2^ADDR_W and remaining decrements.
  - The byte that brings remaining to 0 moves the state to HOLD (or CSUM when the feature is enabled).
  - Its write still occurs at t+1; HOLD begins at t+1.
- HOLD:
  - in_ready=0 and cpu_reset=1.
  - The hold counter counts RST_HOLD cycles, then state becomes RUN.
- RUN:
  - cpu_reset=0, done=1, busy=0.
  - load_req=1 at an edge sets state=LEN and cpu_reset=1 at the next cycle; done clears.
  - Memory contents are not cleared.
- ERROR: cpu_reset=1, err=1, in_ready=0; load_req=1 sets state=LEN and clears err.
- Boundary and corner cases:
  - in_valid while in_ready=0 is ignored; the byte is not lost if the producer holds it.
  - load_req in LEN, DATA, CSUM or HOLD is ignored.
  - A 256-byte load writes addresses 0x00..0xFF; the address counter wraps, with no extra write.
  - reset asserted mid-load aborts immediately to LEN. Partially written memory is left as-is; no further mem_we.
  - mem_we is never high in two consecutive cycles unless bytes are accepted on consecutive edges (throughput: 1 byte/cycle).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - After the last data byte the state goes to CSUM. The next accepted byte is compared with the 8-bit modulo-256 sum of all payload bytes.
  - Match: go to HOLD. Mismatch: go to ERROR (CPU stays in reset, err=1).
- Disabled: no CSUM state, no checksum accumulator, err tied to 0; DATA goes directly to HOLD.

Decomposition:
- Shared package: state encoding constants (LEN=3'd0, DATA=3'd1, CSUM=3'd2, HOLD=3'd3, RUN=3'd4, ERROR=3'd5), and defaults for ADDR_W, DATA_W, RST_HOLD.
- One natural sub-module, loader_wr_port: registers the mem_addr/mem_wdata/mem_we write strobe, driven by the accept pulse and the address counter.
- All other logic stays in prog_loader.

Test Plan:
- Reset then stream 0x03,0xA1,0xB2,0xC3 with continuous valid:
  - Writes 0xA1@0x00, 0xB2@0x01, 0xC3@0x02 on consecutive cycles.
  - cpu_reset falls exactly RST_HOLD=4 cycles after the 0xC3 write; done=1.
- Length byte 0x00 followed by 256 bytes 0x00..0xFF: 256 writes, last 0xFF@0xFF, no write to 0x00 after wrap; then RUN.
- Gap and backpressure: in_valid toggled 1,0,1 with bytes held; in_valid asserted during HOLD is never accepted; no duplicate or missing writes.
- Reset pulled low after 2 of 5 data bytes, then stream 0x01,0x7E: single write 0x7E@0x00; cpu_reset stays 1 until HOLD completes.
- RUN, load_req=1 for one cycle: cpu_reset=1 and done=0 next cycle; a new load of 0x01,0x55 writes 0x55@0x00.
- With LOADER_CHECKSUM_EN: 0x02,0x10,0x20,0x30 gives RUN. 0x02,0x10,0x20,0x31 gives ERROR with err=1 and cpu_reset=1; load_req then returns to LEN with err=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package prog_loader_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int RST_HOLD_DEF = 4;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM) || (s == ST_HOLD);
  endfunction

  function automatic logic takes_input(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_wr_port.sv
// Registered memory write strobe: one mem_we pulse per accepted payload byte.
module loader_wr_port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fire,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  always_comb begin
    we_d    = fire;
    addr_d  = fire ? addr  : addr_q;
    wdata_d = fire ? wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: rtl/prog_loader.sv
// Length-prefixed program loader; holds the CPU in reset while filling memory from 0.
// Optional checksum trailer byte enabled by defining LOADER_CHECKSUM_EN.
//   state | meaning
//   LEN   | waiting for length byte (0 means full address space)
//   DATA  | writing payload bytes
//   CSUM  | waiting for checksum byte (LOADER_CHECKSUM_EN only)
//   HOLD  | keeping cpu_reset high for RST_HOLD cycles
//   RUN   | CPU released
//   ERROR | checksum mismatch, CPU kept in reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] REM_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_FULL  = REM_ONE << ADDR_W;
  localparam logic [3:0]      HOLD_INIT = 4'(RST_HOLD - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_v;
  logic [3:0]        hold_q, hold_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, wr_fire;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
`endif

  assign accept = in_valid && in_ready_q;
  assign len_v  = ADDR_W'(in_data);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    wr_fire = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_LEN: begin
        if (accept) begin
          rem_d   = (len_v == '0) ? REM_FULL : {1'b0, len_v};
          addr_d  = '0;
          state_d = ST_DATA;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_DATA: begin
        if (accept) begin
          wr_fire = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - REM_ONE;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
          if (rem_q == REM_ONE) state_d = ST_CSUM;
`else
          if (rem_q == REM_ONE) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_INIT;
          end
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_INIT;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
`endif
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - 1'b1;
      end
      ST_RUN, ST_ERROR: begin
        if (load_req) state_d = ST_LEN;
      end
      default: state_d = ST_LEN;
    endcase

    // Outputs are registered from the next state so they always match state_q.
    in_ready_d  = takes_input(state_d);
    cpu_reset_d = (state_d != ST_RUN);
    busy_d      = is_busy(state_d);
    done_d      = (state_d == ST_RUN);
`ifdef LOADER_CHECKSUM_EN
    err_d       = (state_d == ST_ERROR);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_LEN;
      rem_q       <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      in_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  loader_wr_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_port (
    .clk       (clk),
    .reset     (reset),
    .fire      (wr_fire),
    .addr      (addr_q),
    .wdata     (in_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  assign in_ready  = in_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus, checked by a write monitor.
module tb_prog_loader;

  localparam int RST_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       load_req = 1'b0;
  logic       in_ready, mem_we, cpu_reset, busy, done, err;
  logic [7:0] mem_addr, mem_wdata;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .RST_HOLD(RST_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          we_cyc[$];
  int          last_we_cyc = 0;
  int          nwrites = 0;
  logic [7:0]  pay[256];
  logic [15:0] mon_e;
  int          n0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      nwrites++;
      last_we_cyc = cyc;
      we_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", int'(mem_addr), int'(mon_e[15:8]));
        chk("wr_data", int'(mem_wdata), int'(mon_e[7:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual in_ready=0 required 1 for byte %0h", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_load(input logic [7:0] lenb, input int n);
    send_byte(lenb);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), pay[i]});
      send_byte(pay[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_run(input int delta);
    int k;
    k = 0;
    while (cpu_reset && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("run_reached", int'(cpu_reset), 0);
    chk("hold_cycles", cyc - last_we_cyc, delta);
    chk("done_in_run", int'(done), 1);
    chk("busy_in_run", int'(busy), 0);
    chk("ready_in_run", int'(in_ready), 0);
    chk("writes_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    chk("reload_cpu_reset", int'(cpu_reset), 1);
    chk("reload_done", int'(done), 0);
    chk("reload_ready", int'(in_ready), 1);
    chk("reload_busy", int'(busy), 1);
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_cpu_reset", int'(cpu_reset), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic 3-byte load with continuous valid
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    we_cyc.delete();
    send_load(8'h03, 3);
    wait_run(RST_HOLD);
    chk("t1_nwrites", we_cyc.size(), 3);
    if (we_cyc.size() == 3) chk("t1_back_to_back", we_cyc[2] - we_cyc[0], 2);

    // Reload from RUN
    restart();
    pay[0] = 8'h55;
    send_load(8'h01, 1);
    wait_run(RST_HOLD);

    // Gaps, load_req ignored in DATA, valid held during HOLD/RUN
    restart();
    send_byte(8'h03);
    exp_q.push_back({8'h00, 8'h11});
    send_byte(8'h11);
    in_valid = 1'b0;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    chk("t3_still_busy", int'(busy), 1);
    chk("t3_still_ready", int'(in_ready), 1);
    exp_q.push_back({8'h01, 8'h22});
    send_byte(8'h22);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    exp_q.push_back({8'h02, 8'h33});
    send_byte(8'h33);
    in_data  = 8'hEE;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t3_hold_not_ready", int'(in_ready), 0);
    chk("t3_hold_cpu_reset", int'(cpu_reset), 1);
    chk("t3_hold_busy", int'(busy), 1);
    wait_run(RST_HOLD);
    in_valid = 1'b0;

    // Full 256-byte load with length byte 0
    restart();
    for (int i = 0; i < 256; i++) pay[i] = 8'(i);
    n0 = nwrites;
    send_load(8'h00, 256);
    wait_run(RST_HOLD);
    chk("t4_write_count", nwrites - n0, 256);

    // Reset mid-load, then a fresh 1-byte load
    restart();
    pay[0] = 8'h01; pay[1] = 8'h02;
    send_byte(8'h05);
    exp_q.push_back({8'h00, 8'h01});
    send_byte(8'h01);
    exp_q.push_back({8'h01, 8'h02});
    send_byte(8'h02);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    chk("t5_partial_writes", exp_q.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pay[0] = 8'h7E;
    send_load(8'h01, 1);
    wait_run(RST_HOLD);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match
    restart();
    send_byte(8'h02);
    exp_q.push_back({8'h00, 8'h10});
    send_byte(8'h10);
    exp_q.push_back({8'h01, 8'h20});
    send_byte(8'h20);
    send_byte(8'h30);
    in_valid = 1'b0;
    wait_run(RST_HOLD + 1);
    chk("cs_ok_err", int'(err), 0);

    // Checksum mismatch
    restart();
    send_byte(8'h02);
    exp_q.push_back({8'h00, 8'h10});
    send_byte(8'h10);
    exp_q.push_back({8'h01, 8'h20});
    send_byte(8'h20);
    send_byte(8'h31);
    in_valid = 1'b0;
    @(negedge clk);
    chk("cs_bad_err", int'(err), 1);
    chk("cs_bad_cpu_reset", int'(cpu_reset), 1);
    chk("cs_bad_ready", int'(in_ready), 0);
    chk("cs_bad_done", int'(done), 0);
    chk("cs_bad_writes", exp_q.size(), 0);
    @(posedge clk);
    #1;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    chk("cs_clear_err", int'(err), 0);
    chk("cs_back_to_len", int'(in_ready), 1);
    chk("cs_len_cpu_reset", int'(cpu_reset), 1);
`else
    chk("err_tied_low", int'(err), 0);
`endif

    repeat (3) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
